// File: rtl/codebreak_tx.sv
// Formats a codebreaker result as an ASCII line for a UART transmitter.
// Define CODEBREAK_TX_KEY_PRINT_EN to prefix each success line with the key in hex and a ':'.
module codebreak_tx (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] bytes_in,
  input  logic [23:0]  key_in,
  input  logic         done,
  input  logic         error,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  output logic         busy,
  output logic         dropped
);

`ifdef CODEBREAK_TX_KEY_PRINT_EN
  typedef enum logic [2:0] {
    StIdle,
    StSendKey,
    StSendSep,
    StSendText,
    StSendErr,
    StSendCr,
    StSendLf
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle,
    StSendText,
    StSendErr,
    StSendCr,
    StSendLf
  } state_e;
`endif

  state_e         state_q, state_d;
  logic [127:0]   text_q, text_d;
  logic [3:0]     txt_idx_q, txt_idx_d;
  logic [1:0]     err_idx_q, err_idx_d;
  logic           dropped_q, dropped_d;
  logic           xfer;

`ifdef CODEBREAK_TX_KEY_PRINT_EN
  logic [23:0]    key_q, key_d;
  logic [2:0]     key_idx_q, key_idx_d;
  logic [23:0]    key_sh;
  logic [3:0]     key_nib;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return {4'h3, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction
`else
  logic           unused_key;
  assign unused_key = ^key_in;
`endif

  logic [127:0]   text_sh;

  assign xfer = tx_valid & tx_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      text_q    <= '0;
      txt_idx_q <= '0;
      err_idx_q <= '0;
      dropped_q <= 1'b0;
`ifdef CODEBREAK_TX_KEY_PRINT_EN
      key_q     <= '0;
      key_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      text_q    <= text_d;
      txt_idx_q <= txt_idx_d;
      err_idx_q <= err_idx_d;
      dropped_q <= dropped_d;
`ifdef CODEBREAK_TX_KEY_PRINT_EN
      key_q     <= key_d;
      key_idx_q <= key_idx_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    text_d    = text_q;
    txt_idx_d = txt_idx_q;
    err_idx_d = err_idx_q;
`ifdef CODEBREAK_TX_KEY_PRINT_EN
    key_d     = key_q;
    key_idx_d = key_idx_q;
`endif
    // Any request arriving while a line is in flight is discarded and flagged.
    dropped_d = (state_q != StIdle) && (done || error);

    unique case (state_q)
      StIdle: begin
        if (done) begin
          text_d  = bytes_in;
`ifdef CODEBREAK_TX_KEY_PRINT_EN
          key_d   = key_in;
          state_d = StSendKey;
`else
          state_d = StSendText;
`endif
        end else if (error) begin
          state_d = StSendErr;
        end
      end
`ifdef CODEBREAK_TX_KEY_PRINT_EN
      StSendKey: begin
        if (xfer) begin
          if (key_idx_q == 3'd5) begin
            key_idx_d = 3'd0;
            state_d   = StSendSep;
          end else begin
            key_idx_d = key_idx_q + 3'd1;
          end
        end
      end
      StSendSep: begin
        if (xfer) begin
          state_d = StSendText;
        end
      end
`endif
      StSendText: begin
        if (xfer) begin
          txt_idx_d = txt_idx_q + 4'd1;
          if (txt_idx_q == 4'd15) begin
            state_d = StSendCr;
          end
        end
      end
      StSendErr: begin
        if (xfer) begin
          if (err_idx_q == 2'd2) begin
            err_idx_d = 2'd0;
            state_d   = StSendCr;
          end else begin
            err_idx_d = err_idx_q + 2'd1;
          end
        end
      end
      StSendCr: begin
        if (xfer) begin
          state_d = StSendLf;
        end
      end
      StSendLf: begin
        if (xfer) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs depend only on registered state, so tx_data holds under backpressure.
  always_comb begin
    tx_valid = (state_q != StIdle);
    busy     = (state_q != StIdle);
    dropped  = dropped_q;
    tx_data  = 8'h00;
    text_sh  = text_q << {txt_idx_q, 3'b000};
`ifdef CODEBREAK_TX_KEY_PRINT_EN
    key_sh   = key_q << {key_idx_q, 2'b00};
    key_nib  = key_sh[23:20];
`endif

    unique case (state_q)
      StIdle:     tx_data = 8'h00;
`ifdef CODEBREAK_TX_KEY_PRINT_EN
      StSendKey:  tx_data = hex_char(key_nib);
      StSendSep:  tx_data = 8'h3A;
`endif
      StSendText: tx_data = text_sh[127:120];
      StSendErr:  tx_data = (err_idx_q == 2'd0) ? 8'h45 : 8'h52;
      StSendCr:   tx_data = 8'h0D;
      StSendLf:   tx_data = 8'h0A;
      default:    tx_data = 8'h00;
    endcase
  end

endmodule
